// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parameterised UART transmitter with an input FIFO. Frames are LSB-first:
//   START(0), DATA_BITS data bits, optional parity, one or two STOP(1) bits.
//   Queued entries go out back-to-back with no idle gap.
//
// Parameters
//   DATA_BITS    payload width per frame (5..9)
//   CLKS_PER_BIT clk cycles per serial bit (>= 2)
//   FIFO_DEPTH   input FIFO entries (power of two, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tx_start   push strobe; data_in is queued when tx_ready=1
//   data_in    payload to queue
//   parity_en  append parity bit (sampled at frame load)
//   parity_odd odd parity when 1, even when 0 (sampled at frame load)
//   two_stop   two stop bits when 1 (sampled at frame load)
//   data_out   registered serial line, idles high
//   tx_ready   FIFO not full
//   tx_busy    frame in progress or FIFO non-empty
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 data_out,
  output logic                 tx_ready,
  output logic                 tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Per-frame configuration, frozen at load so mid-frame mode changes
  // cannot corrupt the frame on the wire.
  typedef struct packed {
    logic par_en;
    logic two_stop;
  } frame_cfg_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  // ---------------------------------------------------------------- FSM
  state_t               state;
  frame_cfg_t           cfg;
  logic [BAUD_W-1:0]    baud;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 baud_last, last_stop;

  assign fifo_empty = (count == '0);
  assign tx_ready   = (count != FULL);
  assign tx_busy    = (state != IDLE) || !fifo_empty;
  assign head       = mem[rd_ptr];
  assign push       = tx_start && tx_ready;

  assign baud_last  = (baud == BAUD_LAST);
  assign last_stop  = (state == STOP) && baud_last && (stop_idx || !cfg.two_stop);
  // Load from IDLE, or chain directly off the last stop cycle so the next
  // START follows with no gap.
  assign pop        = !fifo_empty && ((state == IDLE) || last_stop);

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cfg      <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      data_out <= 1'b1;
    end else if (pop) begin
      state    <= START;
      cfg      <= '{par_en: parity_en, two_stop: two_stop};
      shift    <= head;
      par_bit  <= (^head) ^ parity_odd;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_out <= 1'b0;
    end else if (state == IDLE) begin
      baud     <= '0;
      data_out <= 1'b1;
    end else if (!baud_last) begin
      baud <= baud + BAUD_W'(1);
    end else begin
      baud <= '0;
      case (state)
        START: begin
          state    <= DATA;
          bit_idx  <= '0;
          data_out <= shift[0];
        end
        DATA: begin
          if (bit_idx == BIT_LAST) begin
            if (cfg.par_en) begin
              state    <= PARITY;
              data_out <= par_bit;
            end else begin
              state    <= STOP;
              stop_idx <= 1'b0;
              data_out <= 1'b1;
            end
          end else begin
            bit_idx  <= bit_idx + BIT_W'(1);
            shift    <= shift >> 1;
            data_out <= shift[1];
          end
        end
        PARITY: begin
          state    <= STOP;
          stop_idx <= 1'b0;
          data_out <= 1'b1;
        end
        STOP: begin
          // FIFO non-empty on the last stop cycle is handled by the load
          // branch above.
          if (last_stop) state <= IDLE;
          else           stop_idx <= 1'b1;
          data_out <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
